pipeif_hs: RTL
==============

Name: pipeif_hs

Overview:
Parametrised instruction-fetch stage for the pipelined CPU with interrupt support. It owns the PC register and selects the next PC among sequential, branch, register-jump, jump and exception-vector targets. It fetches through a req/ack instruction-memory handshake that tolerates variable latency, and presents a registered IF/ID payload with a valid bit. It honours ID-stage stalls, delay-slot-preserving redirects, and exception flushes that squash in-flight fetches.

Parameters:
XLEN, 32, width of PC, targets and instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0008, fetch address taken on flush
PC_STEP, 4, sequential increment in bytes

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
pcsource  in  2  00 sequential, 01 bpc, 10 rpc, 11 jpc; non-zero = redirect request this cycle
bpc  in  XLEN  branch target
rpc  in  XLEN  register-jump target
jpc  in  XLEN  jump target
flush  in  1  exception/interrupt squash; next fetch from EXC_VECTOR
id_stall  in  1  ID cannot accept; IF/ID payload must hold
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, stable while imem_req high
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  XLEN  instruction word
if_valid  out  1  IF/ID payload valid
if_pc  out  XLEN  PC of payload instruction
if_pc4  out  XLEN  if_pc + PC_STEP
if_ins  out  XLEN  payload instruction
pc  out  XLEN  current fetch PC (debug)

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC, state=RUN, busy=0, pend_v=0, skid_v=0.
  - if_valid=0; if_pc, if_pc4 and if_ins = 0.
  - imem_req=0 in the cycle reset deasserts.
- States:
  - RUN: normal operation.
  - DRAIN: discard an outstanding response after a flush.
  - SKID: a response is buffered while the payload register is stalled.
- Slot free: slot_free = !if_valid || !id_stall.
- Issue:
  - In RUN with busy=0 and !flush, imem_req=1 and imem_addr=pc, provided slot_free or skid_v=0.
  - Once asserted, imem_req and imem_addr hold until imem_ack (busy=1). imem_req is never withdrawn early.
  - imem_ack may arrive in the first req cycle, which gives one instruction per clock at zero wait states.
- On ack in RUN:
  - If slot_free: load if_valid=1, if_pc=imem_addr, if_pc4=imem_addr+PC_STEP, if_ins=imem_rdata.
  - Otherwise: store into the skid register and go to SKID.
  - In both cases pc advances to pend_v ? pend_pc : imem_addr+PC_STEP, then pend_v clears.
- SKID:
  - No new request is issued.
  - When slot_free, the skid contents move to the payload register and state returns to RUN.
- Payload consumed (if_valid && !id_stall) with nothing new loaded: if_valid goes to 0 next cycle.
- Redirect (pcsource != 0, flush=0):
  - The target (bpc/rpc/jpc) is captured into pend_pc and pend_v is set.
  - The fetch in flight or next issued is the delay slot and completes normally. The fetch after it uses pend_pc.
  - If busy=0 and no payload is pending from that slot, the redirect instead loads pc directly, so the delay slot is the instruction already in IF/ID.
  - A later redirect overwrites an earlier pend_pc.
  - A redirect coincident with ack is applied to the pc update in that same cycle.
- Flush (priority over redirect and ack):
  - Next cycle: if_valid=0, skid_v=0, pend_v=0, pc=EXC_VECTOR.
  - If busy and no ack this cycle, go to DRAIN.
  - DRAIN: imem_req stays high with the old address until ack; the data is discarded; then return to RUN.
  - A flush in DRAIN is absorbed; pc stays EXC_VECTOR.
- Arithmetic: PC addition is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.

Test Plan:
- Zero-wait memory (ack the same cycle as req), id_stall=0 → fetches 0,4,8,C on consecutive cycles; if_pc follows 0,4,8 with if_valid=1 from cycle 1.
- Memory latency 3 cycles → imem_addr held stable for 3 cycles; one instruction every 3 cycles; if_valid pulses once per fetch.
- Assert id_stall for 4 cycles while a request is outstanding → response lands in skid (SKID), no new req issued; on release, if_pc=prev, then skid value, with no instruction lost or duplicated.
- pcsource=01, bpc=0x100 while fetch at 0x20 is in flight → 0x20 (delay slot) delivered, next imem_addr=0x100.
- flush during a 3-cycle outstanding fetch at 0x40 → if_valid=0; req held until ack; data discarded; next imem_addr=0x8; redirect in the same cycle ignored.
- Assert reset mid-DRAIN → imem_req=0, if_valid=0, pc=RESET_PC immediately (asynchronously).

Source files
------------

// File: rtl/pipeif_hs_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and memory.
// The fetch stage is the master; the memory drives ack and read data.
interface pipeif_hs_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pipeif_hs.sv
// Instruction-fetch stage: owns the PC, issues variable-latency fetches and holds the IF/ID payload.
// Handles ID stalls through a one-entry skid buffer, delay-slot redirects and exception flushes.
module pipeif_hs #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR = 'h8,
  parameter int              PC_STEP    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  input  logic            flush,
  input  logic            id_stall,
  pipeif_hs_if.master     imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic [XLEN-1:0] if_ins,
  output logic [XLEN-1:0] pc
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [1:0]      state;
  logic            live;
  logic            busy;
  logic            pend_v;
  logic            skid_v;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_ins;

  logic            slot_free;
  logic            fire;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;

  // live keeps the request low in the first cycle after reset releases.
  always_comb begin
    slot_free      = !if_valid || !id_stall;
    imem.imem_req  = busy || (live && (state == RUN) && !flush && (slot_free || !skid_v));
    imem.imem_addr = busy ? req_addr : pc;
    fire           = imem.imem_req && imem.imem_ack;
    redirect       = (pcsource != 2'b00) && !flush && (state != DRAIN);
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      default: target = jpc;
    endcase
    if (redirect)
      next_pc = target;
    else if (pend_v)
      next_pc = pend_pc;
    else
      next_pc = imem.imem_addr + STEP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      live     <= 1'b0;
      busy     <= 1'b0;
      pend_v   <= 1'b0;
      skid_v   <= 1'b0;
      pc       <= RESET_PC;
      req_addr <= '0;
      pend_pc  <= '0;
      skid_pc  <= '0;
      skid_ins <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_pc4   <= '0;
      if_ins   <= '0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        // An outstanding request cannot be withdrawn, so its response is drained and dropped.
        if_valid <= 1'b0;
        skid_v   <= 1'b0;
        pend_v   <= 1'b0;
        pc       <= EXC_VECTOR;
        busy     <= busy && !fire;
        state    <= (busy && !fire) ? DRAIN : RUN;
      end else if (state == DRAIN) begin
        if (fire) begin
          busy  <= 1'b0;
          state <= RUN;
        end
      end else begin
        if (if_valid && !id_stall)
          if_valid <= 1'b0;
        if ((state == SKID) && slot_free) begin
          if_valid <= 1'b1;
          if_pc    <= skid_pc;
          if_pc4   <= skid_pc + STEP;
          if_ins   <= skid_ins;
          skid_v   <= 1'b0;
          state    <= RUN;
        end
        if (fire) begin
          busy   <= 1'b0;
          pend_v <= 1'b0;
          pc     <= next_pc;
          if (slot_free) begin
            if_valid <= 1'b1;
            if_pc    <= imem.imem_addr;
            if_pc4   <= imem.imem_addr + STEP;
            if_ins   <= imem.imem_rdata;
          end else begin
            skid_v   <= 1'b1;
            skid_pc  <= imem.imem_addr;
            skid_ins <= imem.imem_rdata;
            state    <= SKID;
          end
        end else if (imem.imem_req) begin
          // The fetch now in flight is the delay slot; the target waits for its ack.
          busy     <= 1'b1;
          req_addr <= imem.imem_addr;
          if (redirect) begin
            pend_pc <= target;
            pend_v  <= 1'b1;
          end
        end else if (redirect) begin
          pc <= target;
        end
      end
    end
  end

endmodule
